// File: rtl/fetch_ctrl_s.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_s -- fetch-stage sequencer.
//
// Owns the fetch PC and drives the instruction ROM address/enable. One ROM
// read is issued per un-stalled cycle. Each read carries a {valid, pc} tag
// through a pipe that is ROM_LATENCY stages deep, so the tail tag always
// lines up with rom_instr_i. Stalls freeze everything. Redirects reload the
// PC and kill every in-flight tag. The IF/ID bundle {valid, pc, instr} is
// registered.
//
// Optional build macro: FETCH_PERF_EN
//   Adds the saturating counters perf_stall_cnt and perf_redirect_cnt.
//
// Handshake: there is no valid/ready pair here. The downstream stage
// back-pressures through stall_i. While stall_i is high and redirect_i is
// low, the bundle is held unchanged. if_valid_o marks a bundle that holds a
// real, non-killed instruction.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall_i           freeze fetch (PC, tags, bundle, FSM)
//   redirect_i        one-cycle taken branch/jump; has priority over stall_i
//   redirect_pc_i     redirect target (bits [1:0] ignored)
//   rom_addr_o        ROM word address = fetch_pc[ADDR_W+1:2]
//   rom_en_o          ROM read / output-register enable
//   rom_instr_i       ROM data, ROM_LATENCY enabled cycles after address
//   if_valid_o        bundle holds a real instruction
//   if_pc_o           PC of if_instr_o
//   if_instr_o        fetched instruction
//   busy_o            high while in BOOT or REFILL
//   dbg_state_o       FSM state (0=BOOT, 1=RUN, 2=REFILL)
//   perf_stall_cnt    (FETCH_PERF_EN) stall cycles without redirect
//   perf_redirect_cnt (FETCH_PERF_EN) redirect cycles
// ----------------------------------------------------------------------------
module fetch_ctrl_s #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          ROM_LATENCY = 1,
    parameter int          ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_en_o,
    input  logic [31:0]       rom_instr_i,
    output logic              if_valid_o,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_instr_o,
    output logic              busy_o,
    output logic [1:0]        dbg_state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);

    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_REFILL  = 2'd2;
    localparam logic [1:0] FILL_LAST = 2'(ROM_LATENCY - 1);

    logic [31:0]            r_fetch_pc;
    logic [ROM_LATENCY-1:0] r_tag_v;
    logic [31:0]            r_tag_pc [ROM_LATENCY];
    logic [1:0]             r_state;
    logic [1:0]             r_fill_cnt;
    logic                   r_if_valid;
    logic [31:0]            r_if_pc;
    logic [31:0]            r_if_instr;

    logic                   w_advance;
    logic [31:0]            w_redirect_pc;
    logic                   w_tail_v;
    logic [31:0]            w_tail_pc;

    assign w_advance     = !stall_i && !redirect_i;
    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_tail_v      = r_tag_v[ROM_LATENCY-1];
    assign w_tail_pc     = r_tag_pc[ROM_LATENCY-1];

    // The ROM is also enabled in the redirect cycle. Whatever it captures
    // then lines up with tags that were just cleared, so it is never
    // marked valid.
    assign rom_en_o    = !stall_i || redirect_i;
    assign rom_addr_o  = r_fetch_pc[ADDR_W+1:2];
    assign if_valid_o  = r_if_valid;
    assign if_pc_o     = r_if_pc;
    assign if_instr_o  = r_if_instr;
    assign busy_o      = (r_state != S_RUN);
    assign dbg_state_o = r_state;

    // Fetch PC. Incrementing by 4 wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= PC_RESET;
        end else if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_advance) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Tag pipe. It shifts only on advancing cycles, just as the ROM pipe
    // shifts only when enabled, so head and tail stay matched to the ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_v <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                r_tag_pc[k] <= '0;
            end
        end else if (redirect_i) begin
            r_tag_v <= '0;
        end else if (w_advance) begin
            r_tag_v[0]  <= 1'b1;
            r_tag_pc[0] <= r_fetch_pc;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_pc[k] <= r_tag_pc[k-1];
            end
        end
    end

    // IF/ID bundle. On a redirect, pc/instr keep their last values and only
    // the valid bit drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else if (redirect_i) begin
            r_if_valid <= 1'b0;
        end else if (w_advance) begin
            r_if_valid <= w_tail_v;
            r_if_pc    <= w_tail_pc;
            r_if_instr <= rom_instr_i;
        end
    end

    // BOOT/REFILL wait ROM_LATENCY advancing cycles for the pipe to fill
    // before RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_fill_cnt <= '0;
        end else if (redirect_i) begin
            r_state    <= S_REFILL;
            r_fill_cnt <= '0;
        end else if (w_advance && (r_state != S_RUN)) begin
            if (r_fill_cnt == FILL_LAST) begin
                r_state    <= S_RUN;
                r_fill_cnt <= '0;
            end else begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (stall_i && !redirect_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_i && (r_perf_redirect != 32'hFFFF_FFFF)) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = r_perf_stall;
    assign perf_redirect_cnt = r_perf_redirect;
`endif

endmodule

// File: tb/tb_fetch_ctrl_s.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl_s -- bench for fetch_ctrl_s.
//
// Two instances share one stimulus stream: ROM_LATENCY=1 (index 0) and
// ROM_LATENCY=3 (index 1). Each instance has its own ROM model, where
// ROM[i] = 0xA000_0000 + i. The reference model says that a read is
// delivered once ROM_LATENCY further reads have been issued after it. A
// redirect or reset discards every read issued before it.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl_s;

    localparam logic [1:0] ST_BOOT = 2'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [9:0]  obs_addr  [2];
    logic        obs_en    [2];
    logic        obs_v     [2];
    logic [31:0] obs_pc    [2];
    logic [31:0] obs_instr [2];
    logic        obs_busy  [2];
    logic [1:0]  obs_st    [2];
`ifdef FETCH_PERF_EN
    logic [31:0] perf_s    [2];
    logic [31:0] perf_r    [2];
`endif

    logic [31:0] rom1_d;
    logic [31:0] rom3_d [3];

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and ROM models ----------------
    fetch_ctrl_s #(.PC_RESET(32'h0), .ROM_LATENCY(1), .ADDR_W(10)) u_dut1 (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .rom_addr_o(obs_addr[0]), .rom_en_o(obs_en[0]),
        .rom_instr_i(rom1_d), .if_valid_o(obs_v[0]), .if_pc_o(obs_pc[0]),
        .if_instr_o(obs_instr[0]), .busy_o(obs_busy[0]), .dbg_state_o(obs_st[0])
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_s[0]), .perf_redirect_cnt(perf_r[0])
`endif
    );

    fetch_ctrl_s #(.PC_RESET(32'h0), .ROM_LATENCY(3), .ADDR_W(10)) u_dut3 (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .rom_addr_o(obs_addr[1]), .rom_en_o(obs_en[1]),
        .rom_instr_i(rom3_d[2]), .if_valid_o(obs_v[1]), .if_pc_o(obs_pc[1]),
        .if_instr_o(obs_instr[1]), .busy_o(obs_busy[1]), .dbg_state_o(obs_st[1])
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_s[1]), .perf_redirect_cnt(perf_r[1])
`endif
    );

    always @(posedge clk) begin
        if (obs_en[0]) rom1_d <= 32'hA000_0000 + {22'd0, obs_addr[0]};
    end

    always @(posedge clk) begin
        if (obs_en[1]) begin
            rom3_d[0] <= 32'hA000_0000 + {22'd0, obs_addr[1]};
            rom3_d[1] <= rom3_d[0];
            rom3_d[2] <= rom3_d[1];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_pc  [2];
    logic        m_v   [2];
    logic [31:0] m_opc [2];
    logic [31:0] m_oin [2];
    logic [31:0] iss0 [$];
    logic [31:0] iss1 [$];
`ifdef FETCH_PERF_EN
    logic [31:0] m_perf_s;
    logic [31:0] m_perf_r;
`endif

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? iss0.size() : iss1.size();
    endfunction

    function automatic logic exp_busy(input int i);
        return q_size(i) < lat(i);
    endfunction

    task automatic model_edge(input int i);
        logic [31:0] p;
        if (reset) begin
            m_pc[i] = 32'h0; m_v[i] = 1'b0; m_opc[i] = '0; m_oin[i] = '0;
            if (i == 0) iss0.delete(); else iss1.delete();
        end else if (redirect) begin
            m_pc[i] = {redirect_pc[31:2], 2'b00};
            m_v[i]  = 1'b0;
            if (i == 0) iss0.delete(); else iss1.delete();
        end else if (!stall) begin
            if (i == 0) iss0.push_back(m_pc[i]); else iss1.push_back(m_pc[i]);
            m_pc[i] = m_pc[i] + 32'd4;
            if (q_size(i) > lat(i)) begin
                if (i == 0) p = iss0.pop_front(); else p = iss1.pop_front();
                m_v[i]   = 1'b1;
                m_opc[i] = p;
                m_oin[i] = 32'hA000_0000 + {22'd0, p[11:2]};
            end else begin
                m_v[i] = 1'b0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs(input logic r, input logic s, input logic d,
                                input logic [31:0] t);
        reset = r; stall = s; redirect = d; redirect_pc = t;
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
`ifdef FETCH_PERF_EN
        if (reset) begin
            m_perf_s = 0; m_perf_r = 0;
        end else begin
            if (stall && !redirect) m_perf_s++;
            if (redirect) m_perf_r++;
        end
`endif
        @(negedge clk);
    endtask

    task automatic cycle(input logic r, input logic s, input logic d,
                         input logic [31:0] t);
        drive_inputs(r, s, d, t);
        finish_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h1234);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_v[i] !== 1'b0 || obs_pc[i] !== 32'h0 || obs_instr[i] !== 32'h0 ||
                obs_busy[i] !== 1'b1 || obs_st[i] !== ST_BOOT || obs_addr[i] !== 10'h0) begin
                n_err++;
                $display("FAIL reset[%0d] got v=%b pc=%h in=%h busy=%b st=%0d addr=%h, want 0/0/0/1/BOOT/0",
                         i, obs_v[i], obs_pc[i], obs_instr[i], obs_busy[i], obs_st[i], obs_addr[i]);
            end
        end
    endtask

    task automatic test_stream();
        int first_at [2];
        first_at[0] = 0; first_at[1] = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (obs_v[i] && first_at[i] == 0) first_at[i] = k;
                n_vec++;
                if (obs_v[i] !== m_v[i] || obs_busy[i] !== exp_busy(i)) begin
                    n_err++;
                    $display("FAIL stream[%0d] k=%0d valid/busy got %b/%b want %b/%b",
                             i, k, obs_v[i], obs_busy[i], m_v[i], exp_busy(i));
                end
                if (m_v[i]) begin
                    n_vec++;
                    if (obs_pc[i] !== m_opc[i] || obs_instr[i] !== m_oin[i]) begin
                        n_err++;
                        $display("FAIL stream[%0d] pc/instr got %h/%h want %h/%h",
                                 i, obs_pc[i], obs_instr[i], m_opc[i], m_oin[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (first_at[i] != lat(i) + 1) begin
                n_err++;
                $display("FAIL first_valid[%0d] got cycle %0d want %0d", i, first_at[i], lat(i) + 1);
            end
        end
    endtask

    task automatic test_stall();
        logic found = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 40 && !found; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (m_v[0] && m_opc[0] == 32'h10) found = 1'b1;
        end
        n_vec++;
        if (!found || obs_pc[0] !== 32'h10) begin
            n_err++;
            $display("FAIL stall_setup pc=0x10 not reached, got %h", obs_pc[0]);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            n_vec++;
            if (obs_v[0] !== 1'b1 || obs_pc[0] !== 32'h10 || obs_instr[0] !== 32'hA000_0004) begin
                n_err++;
                $display("FAIL stall_hold got v=%b pc=%h in=%h want 1/00000010/a0000004",
                         obs_v[0], obs_pc[0], obs_instr[0]);
            end
            n_vec++;
            if (obs_v[1] !== m_v[1] || (m_v[1] && obs_pc[1] !== m_opc[1])) begin
                n_err++;
                $display("FAIL stall_hold[1] got v=%b pc=%h want %b/%h", obs_v[1], obs_pc[1], m_v[1], m_opc[1]);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (obs_v[0] !== 1'b1 || obs_pc[0] !== 32'h14 || obs_instr[0] !== 32'hA000_0005) begin
            n_err++;
            $display("FAIL stall_release got v=%b pc=%h in=%h want 1/00000014/a0000005",
                     obs_v[0], obs_pc[0], obs_instr[0]);
        end
    endtask

    task automatic test_redirect();
        logic found = 1'b0;
        int first_at [2];
        first_at[0] = 0; first_at[1] = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 40 && !found; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (m_v[0] && m_opc[0] == 32'h08) found = 1'b1;
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        if (obs_v[0]) first_at[0] = 1;
        if (obs_v[1]) first_at[1] = 1;
        for (int k = 2; k <= 10; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs_v[i] !== m_v[i] || (obs_v[i] && obs_pc[i] == 32'h0C)) begin
                    n_err++;
                    $display("FAIL redirect[%0d] valid got %b pc=%h want %b", i, obs_v[i], obs_pc[i], m_v[i]);
                end
                if (obs_v[i] && first_at[i] == 0) begin
                    first_at[i] = k;
                    n_vec++;
                    if (obs_pc[i] !== 32'h40 || obs_instr[i] !== 32'hA000_0010) begin
                        n_err++;
                        $display("FAIL redirect_target[%0d] got %h/%h want 00000040/a0000010",
                                 i, obs_pc[i], obs_instr[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (first_at[i] != lat(i) + 2) begin
                n_err++;
                $display("FAIL redirect_gap[%0d] first valid at %0d want %0d", i, first_at[i], lat(i) + 2);
            end
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] first_pc [2];
        first_pc[0] = 32'hFFFF_FFFF; first_pc[1] = 32'hFFFF_FFFF;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        drive_inputs(1'b0, 1'b1, 1'b1, 32'h81);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_en[i] !== 1'b1) begin
                n_err++;
                $display("FAIL redir_stall_en[%0d] got %b want 1", i, obs_en[i]);
            end
        end
        finish_cycle();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_addr[i] !== 10'h20 || obs_v[i] !== 1'b0) begin
                n_err++;
                $display("FAIL redir_stall_pc[%0d] got addr=%h v=%b want 020/0", i, obs_addr[i], obs_v[i]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (obs_v[i] && first_pc[i] == 32'hFFFF_FFFF) first_pc[i] = obs_pc[i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (first_pc[i] !== 32'h80) begin
                n_err++;
                $display("FAIL redir_stall_first[%0d] got %h want 00000080", i, first_pc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_at = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 1'b1, 32'h200);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (obs_v[1] && first_at == 0) first_at = k;
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs_v[i] !== m_v[i] || (obs_v[i] && obs_pc[i] < 32'h200)) begin
                    n_err++;
                    $display("FAIL b2b[%0d] got v=%b pc=%h want v=%b pc>=200", i, obs_v[i], obs_pc[i], m_v[i]);
                end
            end
        end
        n_vec++;
        if (first_at != 4) begin
            n_err++;
            $display("FAIL b2b_latency got %0d want 4", first_at);
        end
        // reset in the middle of a refill, with stall and redirect also high
        cycle(1'b0, 1'b0, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h44);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (obs_v[i] !== 1'b0 || obs_pc[i] !== 32'h0 || obs_instr[i] !== 32'h0 ||
                obs_busy[i] !== 1'b1 || obs_st[i] !== ST_BOOT || obs_addr[i] !== 10'h0) begin
                n_err++;
                $display("FAIL mid_reset[%0d] got v=%b pc=%h in=%h busy=%b st=%0d addr=%h",
                         i, obs_v[i], obs_pc[i], obs_instr[i], obs_busy[i], obs_st[i], obs_addr[i]);
            end
        end
    endtask

    task automatic test_random();
        logic r, s, d;
        logic [31:0] t;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 9) < 3);
            d = ($urandom_range(0, 9) == 0);
            t = $urandom;
            drive_inputs(r, s, d, t);
            if (!r) begin
                for (int i = 0; i < 2; i++) begin
                    n_vec++;
                    if (obs_en[i] !== (!s || d) || obs_addr[i] !== m_pc[i][11:2]) begin
                        n_err++;
                        $display("FAIL rand_rom[%0d] got en=%b addr=%h want %b/%h",
                                 i, obs_en[i], obs_addr[i], (!s || d), m_pc[i][11:2]);
                    end
                end
            end
            finish_cycle();
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs_v[i] !== m_v[i] || obs_busy[i] !== exp_busy(i)) begin
                    n_err++;
                    $display("FAIL rand[%0d] k=%0d valid/busy got %b/%b want %b/%b",
                             i, k, obs_v[i], obs_busy[i], m_v[i], exp_busy(i));
                end
                if (m_v[i]) begin
                    n_vec++;
                    if (obs_pc[i] !== m_opc[i] || obs_instr[i] !== m_oin[i]) begin
                        n_err++;
                        $display("FAIL rand[%0d] pc/instr got %h/%h want %h/%h",
                                 i, obs_pc[i], obs_instr[i], m_opc[i], m_oin[i]);
                    end
                end
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (perf_s[i] !== 32'd5 || perf_r[i] !== 32'd2 ||
                perf_s[i] !== m_perf_s || perf_r[i] !== m_perf_r) begin
                n_err++;
                $display("FAIL perf[%0d] got stall=%0d redir=%0d want 5/2", i, perf_s[i], perf_r[i]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_back_to_back();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
